muldiv_sequencer: RTL

//  Multi-cycle sequencer for the EX-stage multiply and divide operations (ALUControl 5 = mul, 51 = div).

---
 rtl/muldiv_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// ============================================================================
//  Module   : muldiv_sequencer
//  Brief    : Radix-2 iterative signed multiply / unsigned divide for the EX
//             stage, one result bit per cycle, with pipeline stall and Done.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               flush,
  output logic               busy,
  output logic               stall,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  localparam int               c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_calc = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_cnt_w-1:0] r_count;
  logic               r_op;
  logic               r_neg;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_opb;

  logic               w_accept;
  logic               w_div0;
  logic               w_last;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_hi_nxt;
  logic [WIDTH-1:0]   w_lo_nxt;
  logic [2*WIDTH-1:0] w_final;

  assign w_accept = start & ~flush & ((r_state == c_idle) | (r_state == c_done));
  assign w_div0   = op & (b == '0);
  assign w_last   = (r_count == c_last);
  assign w_abs_a  = a[WIDTH-1] ? -a : a;
  assign w_abs_b  = b[WIDTH-1] ? -b : b;

  // r_hi/r_lo hold {accumulator, multiplier} for mul and {remainder, dividend->quotient} for div.
  always_comb begin
    w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    w_shift  = {r_hi, r_lo[WIDTH-1]};
    w_diff   = w_shift - {1'b0, r_opb};
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_op) begin
      // Remainder stays below the divisor, so the borrow bit alone decides the quotient bit.
      if (!w_diff[WIDTH]) begin
        w_hi_nxt = w_diff[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_shift[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_hi_nxt = w_sum[WIDTH:1];
      w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    end
    w_final = {w_hi_nxt, w_lo_nxt};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle, c_done: begin
        if (w_accept) begin
          w_state_nxt = w_div0 ? c_done : c_calc;
        end else begin
          w_state_nxt = c_idle;
        end
      end
      c_calc: begin
        if (flush) begin
          w_state_nxt = c_idle;
        end else if (w_last) begin
          w_state_nxt = c_done;
        end
      end
      default: w_state_nxt = c_idle;
    endcase
  end

  always_comb begin
    busy  = (r_state == c_calc);
    done  = (r_state == c_done);
    stall = (r_state == c_calc) | (start & (r_state != c_calc) & ~flush);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= 1'b0;
      r_neg       <= 1'b0;
      r_count     <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_opb       <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_op    <= op;
      r_neg   <= a[WIDTH-1] ^ b[WIDTH-1];
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= op ? a : w_abs_b;
      r_opb   <= op ? b : w_abs_a;
      if (w_div0) begin
        result      <= {a, {WIDTH{1'b1}}};
        div_by_zero <= 1'b1;
      end else begin
        div_by_zero <= 1'b0;
      end
    end else if ((r_state == c_calc) && !flush) begin
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_count <= r_count + 1'b1;
      if (w_last) begin
        result <= (~r_op & r_neg) ? -w_final : w_final;
      end
    end
  end

endmodule

`default_nettype wire
